// File: rtl/vc_allocator_pkg.sv
// Shared NIC definitions for the VC allocator: VC/vnet geometry and a clog2 helper.
package vc_allocator_pkg;

  localparam int N_OF_VC = 2;
  localparam int N_OF_VN = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vc_allocator_first_free.sv
// Lowest-index free VC picker for one vnet: one-hot result plus found flag.
module vc_allocator_first_free #(
  parameter int N = 2
) (
  input  logic [N-1:0] avail_i,
  output logic [N-1:0] onehot_o,
  output logic         found_o
);

  logic [N-1:0] onehot_s;
  logic         found_s;

  // scan upward, first set bit wins
  always_comb begin
    onehot_s = '0;
    found_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (avail_i[k] && !found_s) begin
        onehot_s[k] = 1'b1;
        found_s     = 1'b1;
      end else begin
        onehot_s[k] = onehot_s[k];
      end
    end
  end

  assign onehot_o = onehot_s;
  assign found_o  = found_s;

endmodule

// File: rtl/vc_allocator.sv
// NIC injection VC allocator: priority chain over requests, combinational grants.
// VC_ALLOC_RR_EN selects a registered round-robin start pointer; otherwise request 0 always leads.
module vc_allocator
  import vc_allocator_pkg::*;
#(
  parameter int N_OF_REQUEST   = 3,
  parameter int N_BITS_VNET_ID = clog2(N_OF_VN),
  parameter int N_BITS_VC_ID   = N_OF_VC * N_OF_VN
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [N_OF_REQUEST-1:0]                r_va_i,
  input  logic [N_OF_REQUEST*N_BITS_VNET_ID-1:0] vnet_of_the_request_i,
  input  logic [N_OF_VC*N_OF_VN-1:0]             free_signal_i,
  input  logic [N_OF_VC*N_OF_VN-1:0]             fifo_pointer_state_i,
  output logic [N_OF_REQUEST-1:0]                g_va_o,
  output logic [N_OF_REQUEST*N_BITS_VC_ID-1:0]   g_vc_id_o
);

  localparam int PTR_W = (N_OF_REQUEST > 1) ? clog2(N_OF_REQUEST) : 1;
  localparam int VC_W  = N_OF_VC * N_OF_VN;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    logic [31:0] sum;
    sum = 32'(base) + 32'(off);
    if (sum >= 32'(N_OF_REQUEST)) begin
      sum = sum - 32'(N_OF_REQUEST);
    end else begin
      sum = sum;
    end
    return sum[PTR_W-1:0];
  endfunction

  logic [PTR_W-1:0]        rr_ptr_s;
  logic [VC_W-1:0]         pool_s   [N_OF_REQUEST+1];
  logic [PTR_W-1:0]        idx_s    [N_OF_REQUEST];
  logic [VC_W-1:0]         vc_vec_s [N_OF_REQUEST];
  logic [N_OF_REQUEST-1:0] grant_s;

  assign pool_s[0] = free_signal_i & fifo_pointer_state_i;

  // position p serves request (rr_ptr + p) mod N and consumes its VC from the pool
  for (genvar p = 0; p < N_OF_REQUEST; p++) begin : g_chain
    logic [N_BITS_VNET_ID-1:0] vnet_s;
    logic                      valid_s;
    logic [VC_W-1:0]           shifted_s;
    logic [N_OF_VC-1:0]        onehot_s;
    logic                      found_s;

    assign idx_s[p]  = wrap_add(rr_ptr_s, p);
    assign vnet_s    = vnet_of_the_request_i[32'(idx_s[p]) * N_BITS_VNET_ID +: N_BITS_VNET_ID];
    assign valid_s   = (32'(vnet_s) < 32'(N_OF_VN));
    assign shifted_s = pool_s[p] >> (32'(vnet_s) * N_OF_VC);

    vc_allocator_first_free #(.N(N_OF_VC)) u_first_free (
      .avail_i  (shifted_s[N_OF_VC-1:0]),
      .onehot_o (onehot_s),
      .found_o  (found_s)
    );

    assign grant_s[p]    = r_va_i[idx_s[p]] & valid_s & found_s;
    assign vc_vec_s[p]   = grant_s[p] ? (VC_W'(onehot_s) << (32'(vnet_s) * N_OF_VC)) : '0;
    assign pool_s[p+1]   = pool_s[p] & ~vc_vec_s[p];
  end

  // scatter chain results back to request order; forced low in reset
  always_comb begin
    g_va_o    = '0;
    g_vc_id_o = '0;
    if (rst_n) begin
      for (int p = 0; p < N_OF_REQUEST; p++) begin
        g_va_o[idx_s[p]] = grant_s[p];
        g_vc_id_o[32'(idx_s[p]) * N_BITS_VC_ID +: N_BITS_VC_ID] = N_BITS_VC_ID'(vc_vec_s[p]);
      end
    end else begin
      g_va_o    = '0;
      g_vc_id_o = '0;
    end
  end

`ifdef VC_ALLOC_RR_EN
  logic [PTR_W-1:0] rr_ptr_d;
  logic [PTR_W-1:0] rr_ptr_q;
  logic             hit_s;

  // next start is one past the first granted request in the current order
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    hit_s    = 1'b0;
    for (int p = 0; p < N_OF_REQUEST; p++) begin
      if (grant_s[p] && !hit_s) begin
        rr_ptr_d = wrap_add(idx_s[p], 1);
        hit_s    = 1'b1;
      end else begin
        hit_s    = hit_s;
      end
    end
  end

  // round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr_s = rr_ptr_q;
`else
  logic unused_clk_s;

  assign unused_clk_s = clk;
  assign rr_ptr_s     = '0;
`endif

endmodule

// File: tb/tb_vc_allocator.sv
// Directed table-driven bench for vc_allocator; expectations follow VC_ALLOC_RR_EN when defined.
module tb_vc_allocator;

  logic        clk;
  logic        rst_n;
  logic [2:0]  r_va;
  logic [5:0]  vnet;
  logic [5:0]  free_sig;
  logic [5:0]  fifo;
  logic [2:0]  g_va;
  logic [17:0] g_vc;

  int n_tests;
  int n_fail;

  vc_allocator dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .r_va_i                (r_va),
    .vnet_of_the_request_i (vnet),
    .free_signal_i         (free_sig),
    .fifo_pointer_state_i  (fifo),
    .g_va_o                (g_va),
    .g_vc_id_o             (g_vc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  r_va;
    logic [5:0]  vnet;
    logic [5:0]  free_sig;
    logic [5:0]  fifo;
    logic [2:0]  exp_va;
    logic [17:0] exp_vc;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [2:0] exp_va, input logic [17:0] exp_vc);
    n_tests = n_tests + 1;
    if (g_va !== exp_va || g_vc !== exp_vc) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: g_va=%b g_vc=%b expected g_va=%b g_vc=%b", name, g_va, g_vc, exp_va, exp_vc);
    end
  endtask

  // brief reset pulse between edges so the pointer restarts at 0
  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [2:0] rv, input logic [5:0] vn, input logic [5:0] fr, input logic [5:0] ff);
    r_va     = rv;
    vnet     = vn;
    free_sig = fr;
    fifo     = ff;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(3'b000, 6'b000000, 6'b000000, 6'b000000);

    vecs[0] = '{3'b101, 6'b100101, 6'b011111, 6'b101101, 3'b001, {6'b000000, 6'b000000, 6'b000100}};
    vecs[1] = '{3'b011, 6'b000000, 6'b111111, 6'b111111, 3'b011, {6'b000000, 6'b000010, 6'b000001}};
    vecs[2] = '{3'b111, 6'b101010, 6'b110000, 6'b111111, 3'b011, {6'b000000, 6'b100000, 6'b010000}};
    vecs[3] = '{3'b001, 6'b000011, 6'b111111, 6'b111111, 3'b000, {6'b000000, 6'b000000, 6'b000000}};
    vecs[4] = '{3'b111, 6'b100100, 6'b111111, 6'b111111, 3'b111, {6'b010000, 6'b000100, 6'b000001}};
    vecs[5] = '{3'b010, 6'b000000, 6'b111111, 6'b111111, 3'b010, {6'b000000, 6'b000001, 6'b000000}};
    vecs[6] = '{3'b111, 6'b000000, 6'b111111, 6'b000010, 3'b001, {6'b000000, 6'b000000, 6'b000010}};
    vecs[7] = '{3'b000, 6'b100100, 6'b111111, 6'b111111, 3'b000, {6'b000000, 6'b000000, 6'b000000}};
    vecs[8] = '{3'b111, 6'b001100, 6'b111111, 6'b111111, 3'b101, {6'b000010, 6'b000000, 6'b000001}};

    #12;
    check("reset_idle", 3'b000, 18'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      reset_pulse();
      drive(vecs[i].r_va, vecs[i].vnet, vecs[i].free_sig, vecs[i].fifo);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp_va, vecs[i].exp_vc);
    end

    // rotation across consecutive cycles with constant inputs
    reset_pulse();
    drive(3'b011, 6'b000000, 6'b111111, 6'b111111);
    #1;
    check("rr_c0", 3'b011, {6'b000000, 6'b000010, 6'b000001});
    @(posedge clk);
    #1;
`ifdef VC_ALLOC_RR_EN
    check("rr_c1", 3'b011, {6'b000000, 6'b000001, 6'b000010});
`else
    check("rr_c1", 3'b011, {6'b000000, 6'b000010, 6'b000001});
`endif
    @(posedge clk);
    #1;
    check("rr_c2", 3'b011, {6'b000000, 6'b000010, 6'b000001});
    @(posedge clk);
    #1;

    // reset forces outputs low, release restores request 0 as leader
    drive(3'b111, 6'b000000, 6'b111111, 6'b111111);
    rst_n = 1'b0;
    #1;
    check("in_reset", 3'b000, 18'd0);
    @(posedge clk);
    #1;
    check("in_reset_edge", 3'b000, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release", 3'b011, {6'b000000, 6'b000010, 6'b000001});

    // no available VC: pointer must hold across several edges
    reset_pulse();
    drive(3'b011, 6'b000000, 6'b111111, 6'b111111);
    @(posedge clk);
    #1;
    drive(3'b111, 6'b000000, 6'b111111, 6'b000000);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("no_avail_c%0d", c), 3'b000, 18'd0);
      @(posedge clk);
      #1;
    end
    drive(3'b011, 6'b000000, 6'b111111, 6'b111111);
    #1;
`ifdef VC_ALLOC_RR_EN
    check("ptr_held", 3'b011, {6'b000000, 6'b000001, 6'b000010});
`else
    check("ptr_held", 3'b011, {6'b000000, 6'b000010, 6'b000001});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
